// File: rtl/door_ctrl.sv
// Elevator car door sequencer: open/close motor sequencing, 00-99 BCD dwell timer,
// reopen / early-close / obstruction handling and a latching motor-timeout fault.
module door_ctrl #(
   parameter int unsigned MOVE_TMO = 150
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       arr,
   input  logic       open_req,
   input  logic       close_req,
   input  logic       obstruct,
   input  logic       open_lim,
   input  logic       closed_lim,
   output logic       motor_open,
   output logic       motor_close,
   output logic       move_ok,
   output logic       fault,
   output logic [3:0] q1,
   output logic [3:0] q2,
   output logic [2:0] status
);

   localparam logic [2:0] CLOSED    = 3'd0;
   localparam logic [2:0] OPENING   = 3'd1;
   localparam logic [2:0] OPEN_WAIT = 3'd2;
   localparam logic [2:0] CLOSING   = 3'd3;
   localparam logic [2:0] FAULT     = 3'd4;

   localparam logic [7:0] TMO_LAST = 8'(MOVE_TMO - 1);

   logic [2:0] state_q, state_d;
   logic       arr_d_q;
   logic       arr_edge_q, arr_edge_d;
   logic [3:0] q1_q, q1_d, q2_q, q2_d;
   logic [7:0] wd_q, wd_d;
   logic       move_ok_q, move_ok_d;
   logic       dwell_end, wd_exp, reopen;

   assign dwell_end  = (q2_q == 4'd9) && (q1_q == 4'd9);
   assign wd_exp     = (wd_q == TMO_LAST);
   assign reopen     = open_req | obstruct;
   // Edge is registered so arrival reaches OPENING one clock after arr_d samples it.
   assign arr_edge_d = arr & ~arr_d_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLOSED:    if (arr_edge_q || (arr && open_req)) state_d = OPENING;
         OPENING:   if (open_lim) state_d = OPEN_WAIT;
                    else if (wd_exp) state_d = FAULT;
         OPEN_WAIT: if (!reopen && (close_req || dwell_end)) state_d = CLOSING;
         CLOSING:   if (reopen) state_d = OPENING;
                    else if (closed_lim) state_d = CLOSED;
                    else if (wd_exp) state_d = FAULT;
         FAULT:     state_d = FAULT;
         default:   state_d = CLOSED;
      endcase
   end

   always_comb begin
      q1_d = q1_q;
      q2_d = q2_q;
      if ((state_d == OPEN_WAIT) && (state_q != OPEN_WAIT)) begin
         q1_d = '0;
         q2_d = '0;
      end else if (state_q == OPEN_WAIT) begin
         if (reopen) begin
            q1_d = '0;
            q2_d = '0;
         end else if (!close_req && !dwell_end) begin
            if (q1_q == 4'd9) begin
               q1_d = '0;
               q2_d = q2_q + 4'd1;
            end else begin
               q1_d = q1_q + 4'd1;
            end
         end
      end
   end

   always_comb begin
      wd_d = wd_q;
      if (((state_d == OPENING) || (state_d == CLOSING)) && (state_d != state_q))
         wd_d = '0;
      else if ((state_q == OPENING) || (state_q == CLOSING))
         wd_d = wd_q + 8'd1;
   end

   // Qualifying with state_d drops move_ok on the same edge the car leaves CLOSED.
   assign move_ok_d = (state_q == CLOSED) && (state_d == CLOSED) && closed_lim;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= CLOSED;
         arr_d_q    <= 1'b0;
         arr_edge_q <= 1'b0;
         q1_q       <= '0;
         q2_q       <= '0;
         wd_q       <= '0;
         move_ok_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         arr_d_q    <= arr;
         arr_edge_q <= arr_edge_d;
         q1_q       <= q1_d;
         q2_q       <= q2_d;
         wd_q       <= wd_d;
         move_ok_q  <= move_ok_d;
      end
   end

   assign motor_open  = (state_q == OPENING);
   assign motor_close = (state_q == CLOSING);
   assign fault       = (state_q == FAULT);
   assign status      = state_q;
   assign move_ok     = move_ok_q;
   assign q1          = q1_q;
   assign q2          = q2_q;

endmodule

// File: tb/tb_door_ctrl.sv
// Directed bench for door_ctrl: normal cycle, reopen, early close, obstruction,
// watchdog fault and asynchronous reset, with hand-derived expectations.
module tb_door_ctrl;

   logic       clk = 1'b0;
   logic       clr, arr, open_req, close_req, obstruct, open_lim, closed_lim;
   logic       motor_open, motor_close, move_ok, fault;
   logic [3:0] q1, q2;
   logic [2:0] status;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   door_ctrl #(.MOVE_TMO(150)) dut (
      .clk(clk), .clr(clr), .arr(arr), .open_req(open_req), .close_req(close_req),
      .obstruct(obstruct), .open_lim(open_lim), .closed_lim(closed_lim),
      .motor_open(motor_open), .motor_close(motor_close), .move_ok(move_ok),
      .fault(fault), .q1(q1), .q2(q2), .status(status)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] bcd(input int unsigned v);
      logic [3:0] t, o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_status"}, 8'(status), 8'd0);
      check({tag, "_mopen"}, 8'(motor_open), 8'd0);
      check({tag, "_mclose"}, 8'(motor_close), 8'd0);
      check({tag, "_moveok"}, 8'(move_ok), 8'd0);
      check({tag, "_fault"}, 8'(fault), 8'd0);
      check({tag, "_dwell"}, {q2, q1}, 8'h00);
   endtask

   initial begin
      clr = 1'b0; arr = 1'b0; open_req = 1'b0; close_req = 1'b0;
      obstruct = 1'b0; open_lim = 1'b0; closed_lim = 1'b1;
      #12;
      check_reset_outputs("rst");
      tick(1);
      clr = 1'b1;
      tick(1);
      check("idle_moveok", 8'(move_ok), 8'd1);

      // Normal cycle
      arr = 1'b1;
      tick(1);
      check("arr_k_status", 8'(status), 8'd0);
      arr = 1'b0;
      tick(1);
      check("arr_k1_status", 8'(status), 8'd1);
      check("arr_k1_mopen", 8'(motor_open), 8'd1);
      check("arr_k1_moveok", 8'(move_ok), 8'd0);
      closed_lim = 1'b0;
      tick(9);
      check("opening_hold", 8'(status), 8'd1);
      open_lim = 1'b1;
      tick(1);
      check("ow_entry_status", 8'(status), 8'd2);
      check("ow_entry_dwell", {q2, q1}, 8'h00);
      for (int unsigned i = 1; i <= 99; i++) begin
         tick(1);
         check("dwell_run", {q2, q1}, bcd(i));
      end
      check("dwell99_status", 8'(status), 8'd2);
      tick(1);
      check("dwell_close_status", 8'(status), 8'd3);
      check("dwell_close_mclose", 8'(motor_close), 8'd1);
      check("dwell_close_mopen", 8'(motor_open), 8'd0);
      open_lim = 1'b0;
      tick(9);
      closed_lim = 1'b1;
      tick(1);
      check("closed_status", 8'(status), 8'd0);
      check("closed_moveok0", 8'(move_ok), 8'd0);
      tick(1);
      check("closed_moveok1", 8'(move_ok), 8'd1);

      // Reopen with open_req at dwell 57
      arr = 1'b1;
      tick(1);
      arr = 1'b0;
      tick(1);
      check("reopen_opening", 8'(status), 8'd1);
      closed_lim = 1'b0;
      open_lim = 1'b1;
      tick(1);
      check("reopen_ow", 8'(status), 8'd2);
      tick(57);
      check("reopen_d57", {q2, q1}, 8'h57);
      open_req = 1'b1;
      tick(1);
      check("reopen_d00", {q2, q1}, 8'h00);
      check("reopen_stay", 8'(status), 8'd2);
      close_req = 1'b1;
      tick(1);
      check("open_close_both_status", 8'(status), 8'd2);
      check("open_close_both_dwell", {q2, q1}, 8'h00);
      close_req = 1'b0;
      open_req = 1'b0;
      tick(99);
      check("reopen_d99", {q2, q1}, 8'h99);
      check("reopen_still_ow", 8'(status), 8'd2);
      tick(1);
      check("reopen_closing", 8'(status), 8'd3);

      // Obstruction together with closed_lim in CLOSING
      open_lim = 1'b0;
      tick(3);
      obstruct = 1'b1;
      closed_lim = 1'b1;
      tick(1);
      check("obst_status", 8'(status), 8'd1);
      check("obst_mopen", 8'(motor_open), 8'd1);
      check("obst_moveok", 8'(move_ok), 8'd0);
      obstruct = 1'b0;
      closed_lim = 1'b0;
      open_lim = 1'b1;
      tick(1);
      check("obst_ow", 8'(status), 8'd2);

      // Early close at dwell 20
      tick(20);
      check("early_d20", {q2, q1}, 8'h20);
      close_req = 1'b1;
      tick(1);
      check("early_status", 8'(status), 8'd3);
      check("early_mclose", 8'(motor_close), 8'd1);
      check("early_dwell_hold", {q2, q1}, 8'h20);
      close_req = 1'b0;
      open_lim = 1'b0;
      tick(4);

      // Asynchronous reset mid-CLOSING
      check("pre_rst_mclose", 8'(motor_close), 8'd1);
      #2 clr = 1'b0;
      #1;
      check("async_mclose", 8'(motor_close), 8'd0);
      check("async_status", 8'(status), 8'd0);
      tick(1);
      clr = 1'b1;
      closed_lim = 1'b1;
      tick(1);
      check("post_rst_moveok", 8'(move_ok), 8'd1);

      // Watchdog: OPENING without open_lim
      arr = 1'b1;
      tick(1);
      arr = 1'b0;
      tick(1);
      check("wd_opening", 8'(status), 8'd1);
      closed_lim = 1'b0;
      tick(149);
      check("wd_149", 8'(status), 8'd1);
      tick(1);
      check("wd_fault_status", 8'(status), 8'd4);
      check("wd_fault", 8'(fault), 8'd1);
      check("wd_mopen", 8'(motor_open), 8'd0);
      check("wd_mclose", 8'(motor_close), 8'd0);
      arr = 1'b1; open_req = 1'b1; close_req = 1'b1; closed_lim = 1'b1;
      tick(5);
      check("fault_hold_status", 8'(status), 8'd4);
      check("fault_hold_fault", 8'(fault), 8'd1);
      check("fault_hold_moveok", 8'(move_ok), 8'd0);
      #2 clr = 1'b0;
      #1;
      check_reset_outputs("fault_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
